// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register map, STATUS/CTRL
// field positions and the TX/RX state encodings.
package uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_TX_BUSY  = 4;
  localparam int ST_RXOVR    = 5;
  localparam int ST_FERR     = 6;
  localparam int ST_TXOVF    = 7;

  localparam int CTRL_RX_IE = 16;
  localparam int CTRL_TX_IE = 17;

  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head; simultaneous push and pop are
// accepted even when full, in which case the occupancy is unchanged.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_uart.sv
// Memory-mapped UART: TX/RX FIFOs, runtime baud divisor, sticky error flags
// and a level interrupt on the CPU device bus.
module mmio_uart
  import uart_pkg::*;
#(
  parameter int          CLK_FREQ     = 100000000,
  parameter int          BAUD_DEFAULT = 115200,
  parameter logic [31:0] BASE_ADDR    = 32'h40000010,
  parameter int          TX_DEPTH     = 16,
  parameter int          RX_DEPTH     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);

  localparam logic [15:0] DIV_RESET = 16'(CLK_FREQ / BAUD_DEFAULT);
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;

  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

  logic        sel;
  logic [1:0]  reg_idx;
  logic        tx_push_req, rx_pop_req, status_wr, ctrl_wr;
  logic [15:0] div_q;
  logic        rx_ie_q, tx_ie_q;
  logic        rxovr_q, ferr_q, txovf_q;

  logic [7:0]     tx_head, rx_head;
  logic           tx_full, tx_empty, rx_full, rx_empty;
  logic [TCW-1:0] tx_count;
  logic [RCW-1:0] rx_count;
  logic           tx_pop, rx_push;

  logic unused_bits;
  assign unused_bits = ^{Address[1:0], Write_data[31:18]};

  assign sel         = (Address[31:4] == BASE_ADDR[31:4]);
  assign reg_idx     = Address[3:2];
  assign tx_push_req = Write & sel & (reg_idx == REG_TXDATA);
  assign status_wr   = Write & sel & (reg_idx == REG_STATUS);
  assign ctrl_wr     = Write & sel & (reg_idx == REG_CTRL);
  assign rx_pop_req  = Read & sel & (reg_idx == REG_RXDATA) & ~rx_empty;

  // ---------------- TX FSM
  tx_state_t   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_div_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_shift_q;
  logic        tx_tick, tx_d;

  assign tx_tick = (tx_cnt_q == tx_div_q - 16'd1);
  assign tx_pop  = ~tx_empty & ((tx_state_q == TX_IDLE) | ((tx_state_q == TX_STOP) & tx_tick));

  always_ff @(posedge clk) begin
    if (reset) tx_state_q <= TX_IDLE;
    else       tx_state_q <= tx_state_d;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      TX_IDLE:  if (!tx_empty) tx_state_d = TX_START;
      TX_START: if (tx_tick) tx_state_d = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit_q == 3'd7) tx_state_d = TX_STOP;
      TX_STOP:  if (tx_tick) tx_state_d = tx_empty ? TX_IDLE : TX_START;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    unique case (tx_state_q)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_shift_q[tx_bit_q];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx       <= 1'b1;
    end else begin
      tx <= tx_d;
      if (tx_pop) begin
        tx_cnt_q <= '0;
        tx_bit_q <= '0;
      end else if (tx_state_q != TX_IDLE) begin
        if (tx_tick) begin
          tx_cnt_q <= '0;
          if (tx_state_q == TX_DATA) tx_bit_q <= tx_bit_q + 3'd1;
        end else begin
          tx_cnt_q <= tx_cnt_q + 16'd1;
        end
      end
    end
  end

  // The divisor is captured per frame so a CTRL write never distorts a byte in flight.
  always_ff @(posedge clk) begin
    if (tx_pop) begin
      tx_shift_q <= tx_head;
      tx_div_q   <= div_q;
    end
  end

  // ---------------- RX synchroniser and FSM
  logic        rx_p0, rx_p1, rx_prev;
  rx_state_t   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_div_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shift_q;
  logic        rx_fall, rx_tick, rx_half_tick, rx_stop_tick, ferr_set, rxovr_set;

  assign rx_fall      = rx_prev & ~rx_p1;
  assign rx_tick      = (rx_cnt_q == rx_div_q - 16'd1);
  assign rx_half_tick = (rx_cnt_q == {1'b0, rx_div_q[15:1]} - 16'd1);
  assign rx_stop_tick = (rx_state_q == RX_STOP) & rx_tick;

  always_ff @(posedge clk) begin
    if (reset) rx_state_q <= RX_IDLE;
    else       rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      RX_IDLE:  if (rx_fall) rx_state_d = RX_START;
      RX_START: if (rx_half_tick) rx_state_d = rx_p1 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      RX_STOP:  if (rx_tick) rx_state_d = rx_p1 ? RX_IDLE : RX_BREAK;
      RX_BREAK: if (rx_p1) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_push   = rx_stop_tick & rx_p1;
    ferr_set  = rx_stop_tick & ~rx_p1;
    rxovr_set = rx_push & rx_full & ~rx_pop_req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_p0    <= 1'b1;
      rx_p1    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
    end else begin
      rx_p0   <= rx;
      rx_p1   <= rx_p0;
      rx_prev <= rx_p1;
      unique case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          rx_bit_q <= '0;
        end
        RX_START: rx_cnt_q <= rx_half_tick ? 16'd0 : rx_cnt_q + 16'd1;
        RX_DATA: begin
          rx_cnt_q <= rx_tick ? 16'd0 : rx_cnt_q + 16'd1;
          if (rx_tick) rx_bit_q <= rx_bit_q + 3'd1;
        end
        RX_STOP:  rx_cnt_q <= rx_cnt_q + 16'd1;
        default:  rx_cnt_q <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_state_q == RX_IDLE && rx_fall) rx_div_q <= div_q;
    if (rx_state_q == RX_DATA && rx_tick) rx_shift_q <= {rx_p1, rx_shift_q[7:1]};
  end

  // ---------------- FIFOs
  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push_req), .din(Write_data[7:0]), .pop(tx_pop),
    .head(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .din(rx_shift_q), .pop(rx_pop_req),
    .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // ---------------- Registers, sticky flags, irq
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= DIV_RESET;
      rx_ie_q <= 1'b0;
      tx_ie_q <= 1'b0;
      rxovr_q <= 1'b0;
      ferr_q  <= 1'b0;
      txovf_q <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        div_q   <= clamp_div(Write_data[15:0]);
        rx_ie_q <= Write_data[CTRL_RX_IE];
        tx_ie_q <= Write_data[CTRL_TX_IE];
      end
      // A set event in the same cycle as the W1C write keeps the flag set.
      rxovr_q <= rxovr_set | (rxovr_q & ~(status_wr & Write_data[ST_RXOVR]));
      ferr_q  <= ferr_set  | (ferr_q  & ~(status_wr & Write_data[ST_FERR]));
      txovf_q <= (tx_push_req & tx_full & ~tx_pop) | (txovf_q & ~(status_wr & Write_data[ST_TXOVF]));
      irq     <= (rx_ie_q & ~rx_empty) | (tx_ie_q & tx_empty);
    end
  end

  always_comb begin
    Read_data = '0;
    if (Read && sel) begin
      unique case (reg_idx)
        REG_RXDATA: if (!rx_empty) Read_data = {24'b0, rx_head};
        REG_STATUS: Read_data = {8'b0, 8'(tx_count), 8'(rx_count), txovf_q, ferr_q, rxovr_q,
                                 (tx_state_q != TX_IDLE), rx_full, rx_empty, tx_empty, tx_full};
        REG_CTRL:   Read_data = {14'b0, tx_ie_q, rx_ie_q, div_q};
        default:    Read_data = '0;
      endcase
    end
  end

endmodule
